// File: rtl/decode_regfile_scoreboard.sv
// Decode-stage register file with per-register in-flight write scoreboard.
// Operands bypass same-cycle writeback; DepStall holds issue until producers retire.
module decode_regfile_scoreboard #(
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                         I_CLOCK,
    input  logic                         I_LOCK,
    input  logic                         I_WriteBackEnable,
    input  logic [$clog2(NUM_REGS)-1:0]  I_WriteBackRegIdx,
    input  logic [REG_WIDTH-1:0]         I_WriteBackData,
    input  logic                         I_IssueValid,
    input  logic                         I_Src1Use,
    input  logic [$clog2(NUM_REGS)-1:0]  I_Src1RegIdx,
    input  logic                         I_Src2Use,
    input  logic [$clog2(NUM_REGS)-1:0]  I_Src2RegIdx,
    input  logic                         I_DestEn,
    input  logic [$clog2(NUM_REGS)-1:0]  I_DestRegIdx,
    input  logic                         I_Flush,
    output logic [REG_WIDTH-1:0]         O_Src1Data,
    output logic [REG_WIDTH-1:0]         O_Src2Data,
    output logic                         O_DepStall,
    output logic                         O_IssueAccept,
    output logic                         O_Underflow
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [REG_WIDTH-1:0] regs     [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt      [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_next [NUM_REGS];

    logic src1_hazard;
    logic src2_hazard;
    logic dest_full;

    // Operand read with same-cycle writeback bypass
    always_comb begin
        O_Src1Data = regs[I_Src1RegIdx];
        O_Src2Data = regs[I_Src2RegIdx];
        if (I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1RegIdx)) O_Src1Data = I_WriteBackData;
        if (I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2RegIdx)) O_Src2Data = I_WriteBackData;
    end

    // A source is clear if idle or its last outstanding write retires this cycle
    always_comb begin
        src1_hazard = I_Src1Use && (cnt[I_Src1RegIdx] != '0)
                      && !(I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1RegIdx)
                           && (cnt[I_Src1RegIdx] == CNT_ONE));
        src2_hazard = I_Src2Use && (cnt[I_Src2RegIdx] != '0)
                      && !(I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2RegIdx)
                           && (cnt[I_Src2RegIdx] == CNT_ONE));
        dest_full   = I_DestEn && (cnt[I_DestRegIdx] == CNT_MAX)
                      && !(I_WriteBackEnable && (I_WriteBackRegIdx == I_DestRegIdx));
        O_DepStall    = I_IssueValid && (src1_hazard || src2_hazard || dest_full);
        O_IssueAccept = I_IssueValid && !O_DepStall && !I_Flush;
    end

    // Scoreboard next state: saturating inc on issue, dec on retire, flush clears
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            cnt_next[r] = cnt[r];
            inc = O_IssueAccept && I_DestEn && (I_DestRegIdx == IDX_W'(r));
            dec = I_WriteBackEnable && (I_WriteBackRegIdx == IDX_W'(r)) && (cnt[r] != '0);
            if (I_Flush) begin
                cnt_next[r] = '0;
            end else if (inc && !dec && (cnt[r] != CNT_MAX)) begin
                cnt_next[r] = cnt[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_next[r] = cnt[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            O_Underflow <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (I_WriteBackEnable) begin
                regs[I_WriteBackRegIdx] <= I_WriteBackData;
                if (cnt[I_WriteBackRegIdx] == '0) O_Underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
// Directed self-checking bench for decode_regfile_scoreboard.
module tb_decode_regfile_scoreboard;

    logic        clk;
    logic        lock;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic [15:0] wb_data;
    logic        issue_valid;
    logic        src1_use;
    logic [3:0]  src1_idx;
    logic        src2_use;
    logic [3:0]  src2_idx;
    logic        dest_en;
    logic [3:0]  dest_idx;
    logic        flush;
    logic [15:0] src1_data;
    logic [15:0] src2_data;
    logic        dep_stall;
    logic        issue_accept;
    logic        underflow;

    int unsigned n_checks;
    int unsigned n_fails;

    decode_regfile_scoreboard #(
        .REG_WIDTH (16),
        .NUM_REGS  (16),
        .CNT_WIDTH (2)
    ) dut (
        .I_CLOCK           (clk),
        .I_LOCK            (lock),
        .I_WriteBackEnable (wb_en),
        .I_WriteBackRegIdx (wb_idx),
        .I_WriteBackData   (wb_data),
        .I_IssueValid      (issue_valid),
        .I_Src1Use         (src1_use),
        .I_Src1RegIdx      (src1_idx),
        .I_Src2Use         (src2_use),
        .I_Src2RegIdx      (src2_idx),
        .I_DestEn          (dest_en),
        .I_DestRegIdx      (dest_idx),
        .I_Flush           (flush),
        .O_Src1Data        (src1_data),
        .O_Src2Data        (src2_data),
        .O_DepStall        (dep_stall),
        .O_IssueAccept     (issue_accept),
        .O_Underflow       (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wb_en       = 1'b0;
        wb_idx      = '0;
        wb_data     = '0;
        issue_valid = 1'b0;
        src1_use    = 1'b0;
        src1_idx    = '0;
        src2_use    = 1'b0;
        src2_idx    = '0;
        dest_en     = 1'b0;
        dest_idx    = '0;
        flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s1u, input logic [3:0] s1, input logic s2u,
                         input logic [3:0] s2, input logic de, input logic [3:0] d);
        issue_valid = 1'b1;
        src1_use    = s1u;
        src1_idx    = s1;
        src2_use    = s2u;
        src2_idx    = s2;
        dest_en     = de;
        dest_idx    = d;
    endtask

    task automatic wb(input logic [3:0] idx, input logic [15:0] data);
        wb_en   = 1'b1;
        wb_idx  = idx;
        wb_data = data;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        lock     = 1'b0;
        idle();

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        src1_idx = 4'd3;
        src2_idx = 4'd15;
        #1;
        check("rst_src1", 32'(src1_data), 32'h0);
        check("rst_src2", 32'(src2_data), 32'h0);
        check("rst_stall", 32'(dep_stall), 32'h0);
        check("rst_accept", 32'(issue_accept), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        lock = 1'b1;
        tick();

        idle(); issue(1'b1, 4'd3, 1'b1, 4'd15, 1'b0, 4'd0); #2;
        check("post_rst_src1", 32'(src1_data), 32'h0);
        check("post_rst_src2", 32'(src2_data), 32'h0);
        check("post_rst_stall", 32'(dep_stall), 32'h0);
        check("post_rst_accept", 32'(issue_accept), 32'h1);
        tick();

        // Write and bypass on R5 (pending first, so no underflow)
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5); #2;
        check("r5_dest_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); wb(4'd5, 16'h1234); src1_idx = 4'd5; src2_idx = 4'd0; #2;
        check("bypass_src1", 32'(src1_data), 32'h1234);
        check("bypass_src2_other", 32'(src2_data), 32'h0);
        tick();
        idle(); src1_idx = 4'd5; #2;
        check("r5_hold", 32'(src1_data), 32'h1234);
        check("r5_no_underflow", 32'(underflow), 32'h0);

        // RAW stall on R2
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2); #2;
        check("r2_dest_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0); #2;
        check("raw_stall_c1", 32'(dep_stall), 32'h1);
        check("raw_accept_c1", 32'(issue_accept), 32'h0);
        tick();
        #2;
        check("raw_stall_c2", 32'(dep_stall), 32'h1);
        tick();
        wb(4'd2, 16'h00AA); #2;
        check("raw_clear_stall", 32'(dep_stall), 32'h0);
        check("raw_clear_data", 32'(src1_data), 32'h00AA);
        check("raw_clear_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0); #2;
        check("raw_retired", 32'(dep_stall), 32'h0);
        tick();

        // Unused sources never stall on a pending register
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2); #2;
        check("r2_repend_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b0, 4'd2, 1'b0, 4'd2, 1'b0, 4'd0); #2;
        check("unused_src_no_stall", 32'(dep_stall), 32'h0);
        tick();

        // WAW saturation on R7
        for (int k = 0; k < 3; k++) begin
            idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7); #2;
            check("waw_fill_accept", 32'(issue_accept), 32'h1);
            tick();
        end
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7); #2;
        check("waw_full_stall", 32'(dep_stall), 32'h1);
        check("waw_full_accept", 32'(issue_accept), 32'h0);
        tick();
        wb(4'd7, 16'h0707); #2;
        check("waw_wb_stall", 32'(dep_stall), 32'h0);
        check("waw_wb_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7); #2;
        check("waw_still_full", 32'(dep_stall), 32'h1);
        tick();
        idle(); wb(4'd7, 16'h0001); tick();
        idle(); wb(4'd7, 16'h0002); tick();
        idle(); issue(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0); #2;
        check("waw_busy_cnt1", 32'(dep_stall), 32'h1);
        tick();
        wb(4'd7, 16'h0777); #2;
        check("waw_clearing_stall", 32'(dep_stall), 32'h0);
        check("waw_clearing_data", 32'(src1_data), 32'h0777);
        tick();
        idle(); issue(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0); #2;
        check("waw_retired", 32'(dep_stall), 32'h0);
        check("waw_no_underflow", 32'(underflow), 32'h0);
        tick();

        // Flush squashes R1, R4 (and R2) pending and the R9 issue
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1); #2;
        check("r1_dest_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4); #2;
        check("r4_dest_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b1, 4'd1, 1'b1, 4'd4, 1'b0, 4'd0); #2;
        check("pre_flush_busy", 32'(dep_stall), 32'h1);
        tick();
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd9); flush = 1'b1; #2;
        check("flush_accept", 32'(issue_accept), 32'h0);
        check("flush_stall", 32'(dep_stall), 32'h0);
        tick();
        idle(); issue(1'b1, 4'd1, 1'b1, 4'd4, 1'b0, 4'd0); #2;
        check("post_flush_stall", 32'(dep_stall), 32'h0);
        check("post_flush_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); issue(1'b1, 4'd9, 1'b1, 4'd2, 1'b0, 4'd0); #2;
        check("r9_not_pending", 32'(dep_stall), 32'h0);
        tick();

        // Underflow: writeback to an idle register
        idle(); wb(4'd10, 16'hBEEF); src1_idx = 4'd10; src2_idx = 4'd10; #2;
        check("uf_bypass_src1", 32'(src1_data), 32'hBEEF);
        check("uf_bypass_src2", 32'(src2_data), 32'hBEEF);
        check("uf_not_yet", 32'(underflow), 32'h0);
        tick();
        idle(); src1_idx = 4'd10; #2;
        check("uf_reg_written", 32'(src1_data), 32'hBEEF);
        check("uf_set", 32'(underflow), 32'h1);
        repeat (3) tick();
        check("uf_sticky", 32'(underflow), 32'h1);

        // Async reset mid-operation clears registers, counters and the error flag
        idle(); issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3); #2;
        check("r3_dest_accept", 32'(issue_accept), 32'h1);
        tick();
        idle(); #2;
        lock = 1'b0;
        src1_idx = 4'd10;
        src2_idx = 4'd5;
        #1;
        check("arst_underflow", 32'(underflow), 32'h0);
        check("arst_r10", 32'(src1_data), 32'h0);
        check("arst_r5", 32'(src2_data), 32'h0);
        tick();
        lock = 1'b1;
        tick();
        idle(); issue(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0); #2;
        check("arst_pending_cleared", 32'(dep_stall), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/decode_regfile_scoreboard.md
Name: decode_regfile_scoreboard

Overview:
Decode-stage receiver for the writeback write port: owns the 16-entry architectural register file and a per-register in-flight-write scoreboard. Accepts (enable, index, data) writes from writeback, supplies two source operands to decode with same-cycle write bypass, and generates the dependency stall (DepStall) that holds issue until producers retire. Sits between the writeback and decode stages; its DepStall feeds downstream stages as a bubble qualifier.

Parameters:
REG_WIDTH, 16, data width of each register (matches `REG_WIDTH)
NUM_REGS, 16, number of architectural registers (index width 4)
CNT_WIDTH, 2, width of per-register pending-write counter; max in-flight writes per register = 2^CNT_WIDTH-1

Ports:
I_CLOCK  in  1  clock, all state updates on rising edge
I_LOCK  in  1  asynchronous active-low reset (low = clear all state)
I_WriteBackEnable  in  1  write strobe from writeback
I_WriteBackRegIdx  in  4  write destination index
I_WriteBackData  in  REG_WIDTH  write data
I_IssueValid  in  1  decode presents an instruction this cycle
I_Src1Use  in  1  instruction reads source 1
I_Src1RegIdx  in  4  source 1 index
I_Src2Use  in  1  instruction reads source 2
I_Src2RegIdx  in  4  source 2 index
I_DestEn  in  1  instruction writes a register
I_DestRegIdx  in  4  destination index
I_Flush  in  1  synchronous squash of all in-flight writes (branch redirect)
O_Src1Data  out  REG_WIDTH  source 1 operand
O_Src2Data  out  REG_WIDTH  source 2 operand
O_DepStall  out  1  issue blocked this cycle
O_IssueAccept  out  1  issue accepted this cycle (= I_IssueValid & !O_DepStall & !I_Flush)
O_Underflow  out  1  sticky error: writeback to register with zero pending count

Behaviour:
- Reset (I_LOCK low, async): all registers = 0, all counters = 0, O_Underflow = 0. Outputs combinational from state, so O_Src*Data = 0, O_DepStall = 0, O_IssueAccept = 0 (inputs idle).
- Register write: on edge with I_WriteBackEnable=1, reg[I_WriteBackRegIdx] <= I_WriteBackData. Written regardless of counter value or I_Flush.
- Operand read: combinational. If I_WriteBackEnable and index equals source index, output I_WriteBackData (bypass); else reg[idx]. Zero latency.
- busy(r) = cnt[r] != 0. clearing(r) = I_WriteBackEnable & I_WriteBackRegIdx==r & cnt[r]==1.
- O_DepStall = I_IssueValid & ( (I_Src1Use & busy(src1) & !clearing(src1)) | (I_Src2Use & busy(src2) & !clearing(src2)) | (I_DestEn & cnt[dest]==MAX & !(I_WriteBackEnable & I_WriteBackRegIdx==dest)) ). Unused sources never stall.
- Counter update per edge, per register r: inc = O_IssueAccept & I_DestEn & dest==r; dec = I_WriteBackEnable & wbidx==r & cnt[r]!=0. inc&dec -> unchanged; inc -> +1; dec -> -1. Never wraps past MAX or below 0.
- Writeback with cnt[r]==0: data still written, counter stays 0, O_Underflow <= 1 (sticky until reset).
- I_Flush=1: all counters <= 0 on that edge (overrides inc/dec); O_IssueAccept forced 0; register writes still occur.
- Write-after-write: older writeback decrements only; register stays busy until last outstanding write retires.
- Reset mid-operation: all counters and registers clear immediately; no pending-state survives.

Test Plan:
- Reset then read: I_LOCK low 2 cycles, release; Src1=R3, Src2=R15 -> O_Src1Data=0, O_Src2Data=0, O_DepStall=0.
- Write/bypass: WB R5=0x1234; same cycle Src1=R5 -> O_Src1Data=0x1234; next cycle (no WB) -> still 0x1234.
- RAW stall: issue dest R2 (accepted, cnt=1); next cycle issue Src1=R2 -> O_DepStall=1 for each cycle until WB R2=0x00AA, in which cycle DepStall=0 and O_Src1Data=0x00AA.
- WAW/saturation: issue dest R7 three times (cnt=3); fourth issue dest R7 -> DepStall=1; WB R7 same cycle -> DepStall=0, cnt stays 3; two WBs R7 -> R7 still busy (cnt=1).
- Flush: issue dest R1, R4 pending; I_Flush=1 with IssueValid dest R9 -> O_IssueAccept=0; next cycle Src1=R1, Src2=R4, Src1Use/Src2Use=1 -> DepStall=0, cnt[R9]=0.
- Underflow: WB R10=0xBEEF with cnt[R10]=0 -> reg R10=0xBEEF, O_Underflow=1 and stays 1 until I_LOCK low.
